biu_prefetch_queue: RTL and testbench

// - Bus-interface prefetch queue directly upstream of the EU register/ALU stage.
// - Fetches 16-bit words from memory ahead of execution into a QUEUE_BYTES byte FIFO.
// - Presents head bytes to the EU in its 32-bit instruction_and_imm packing; EU pops 0..4 bytes per cycle.
// - Flush (jump/reset vector) discards queue contents and restarts fetch at a new linear address.

---
 rtl/biu_prefetch_queue.sv | 211 +++++++++++++++++++++
 tb/tb_biu_prefetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/biu_prefetch_queue.sv
`timescale 1ns/1ps
// ============================================================================
// biu_prefetch_queue
// ----------------------------------------------------------------------------
// Bus-interface prefetch queue feeding the EU register/ALU stage. Fetches
// little-endian 16-bit words ahead of execution into a QUEUE_BYTES byte FIFO
// and presents the head bytes to the EU in its instruction/immediate packing.
// A flush discards the queue and restarts fetching at a new linear address.
//
// Optional feature macro: PFQ_STATS_EN (adds fetch_count / flush_count).
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   flush            discard queue, load fetch pointer from flush_addr
//   flush_addr       new linear fetch address (odd allowed)
//   mem_req          fetch request, held until mem_ack
//   mem_addr         even word address, stable while mem_req=1
//   mem_ack          1-cycle acknowledge, mem_rdata valid same cycle
//   mem_rdata        [7:0]=byte at addr, [15:8]=byte at addr+1
//   q_avail          bytes currently queued
//   q_bytes          head bytes {b3,b2,b1,b0}, bytes beyond q_avail read 0
//   eu_imm_sel       1: eu_word={b0,b1,b3,b2}; 0: eu_word={16'h0,b0,b1}
//   eu_word          EU packing of the head bytes
//   eu_consume       bytes popped this cycle (0..4)
//   consume_err      1-cycle pulse when eu_consume exceeded q_avail
//   fetch_count      [PFQ_STATS_EN] completed, non-discarded fetches
//   flush_count      [PFQ_STATS_EN] accepted flush cycles
// ============================================================================
module biu_prefetch_queue #(
    parameter int QUEUE_BYTES     = 6,
    parameter int ADDR_SIZE       = 20,
    parameter int FETCH_THRESHOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_SIZE-1:0] flush_addr,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_rdata,
    output logic [2:0]           q_avail,
    output logic [31:0]          q_bytes,
    input  logic                 eu_imm_sel,
    output logic [31:0]          eu_word,
    input  logic [2:0]           eu_consume,
    output logic                 consume_err
`ifdef PFQ_STATS_EN
    ,
    output logic [15:0]          fetch_count,
    output logic [15:0]          flush_count
`endif
);

    localparam int IDX_W = $clog2(QUEUE_BYTES);
    localparam int CNT_W = $clog2(QUEUE_BYTES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]     head_q, head_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 consume_err_q, consume_err_d;
    logic [7:0]           mem_q [QUEUE_BYTES];
    logic [7:0]           mem_d [QUEUE_BYTES];

    logic                 accept_ack;
    logic [IDX_W-1:0]     tail;
    logic [CNT_W-1:0]     wr_cnt;
    logic [CNT_W-1:0]     free_bytes;
    logic [CNT_W-1:0]     need_bytes;
    logic [CNT_W-1:0]     consume_ext;
    logic [7:0]           b [4];

    // Circular index add; off never exceeds QUEUE_BYTES so one subtract suffices.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input logic [CNT_W-1:0] off);
        int unsigned s;
        s = 32'(base) + 32'(off);
        if (s >= 32'(QUEUE_BYTES)) s = s - 32'(QUEUE_BYTES);
        return IDX_W'(s);
    endfunction

    assign accept_ack  = (state_q == ST_REQ) && mem_ack && !flush;
    assign tail        = idx_add(head_q, count_q);
    assign free_bytes  = CNT_W'(QUEUE_BYTES) - count_q;
    assign need_bytes  = ptr_q[0] ? CNT_W'(1) : CNT_W'(2);
    assign consume_ext = CNT_W'(eu_consume);

    // Only one fetch is ever outstanding and no new one issues until it
    // resolves, so the reservation is implicit: IDLE always sees zero reserved.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        mem_addr_d    = mem_addr_q;
        head_d        = head_q;
        count_d       = count_q;
        consume_err_d = 1'b0;
        wr_cnt        = '0;
        for (int unsigned i = 0; i < QUEUE_BYTES; i++) mem_d[i] = mem_q[i];

        // Tail write of the fetched word (odd pointer keeps the high byte only).
        if (accept_ack) begin
            if (ptr_q[0]) begin
                mem_d[tail] = mem_rdata[15:8];
                wr_cnt      = CNT_W'(1);
            end else begin
                mem_d[tail]                     = mem_rdata[7:0];
                mem_d[idx_add(tail, CNT_W'(1))] = mem_rdata[15:8];
                wr_cnt                          = CNT_W'(2);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!flush && free_bytes >= CNT_W'(FETCH_THRESHOLD) &&
                    free_bytes >= need_bytes) begin
                    state_d    = ST_REQ;
                    mem_addr_d = {ptr_q[ADDR_SIZE-1:1], 1'b0};
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (!flush) ptr_d = ptr_q + (ptr_q[0] ? ADDR_SIZE'(1) : ADDR_SIZE'(2));
                end else if (flush) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            head_d  = '0;
            count_d = '0;
            ptr_d   = flush_addr;
        end else if (consume_ext > count_q) begin
            consume_err_d = 1'b1;
            count_d       = count_q + wr_cnt;
        end else begin
            head_d  = idx_add(head_q, consume_ext);
            count_d = count_q + wr_cnt - consume_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            mem_addr_q    <= '0;
            head_q        <= '0;
            count_q       <= '0;
            consume_err_q <= 1'b0;
            for (int unsigned i = 0; i < QUEUE_BYTES; i++) mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            mem_addr_q    <= mem_addr_d;
            head_q        <= head_d;
            count_q       <= count_d;
            consume_err_q <= consume_err_d;
            for (int unsigned i = 0; i < QUEUE_BYTES; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            b[i] = (i < 32'(count_q)) ? mem_q[idx_add(head_q, CNT_W'(i))] : 8'h00;
        end
        q_bytes = {b[3], b[2], b[1], b[0]};
        eu_word = eu_imm_sel ? {b[0], b[1], b[3], b[2]} : {16'h0000, b[0], b[1]};
    end

    assign q_avail     = 3'(count_q);
    assign mem_req     = (state_q != ST_IDLE);
    assign mem_addr    = mem_addr_q;
    assign consume_err = consume_err_q;

`ifdef PFQ_STATS_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 16'(accept_ack);
        flush_count_d = flush_count_q + 16'(flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    // Statistics counters not built.
`endif

endmodule

// File: tb/tb_biu_prefetch_queue.sv
`timescale 1ns/1ps
// ============================================================================
// tb_biu_prefetch_queue
// ----------------------------------------------------------------------------
// Directed bench for biu_prefetch_queue: a memory responder driven by hand,
// with hand-computed queue contents, EU packing, flush/discard handling,
// consume errors and address wrap. Counters checked when PFQ_STATS_EN is set.
// ============================================================================
module tb_biu_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [19:0] flush_addr;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  q_avail;
    logic [31:0] q_bytes;
    logic        eu_imm_sel;
    logic [31:0] eu_word;
    logic [2:0]  eu_consume;
    logic        consume_err;
`ifdef PFQ_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int checks;
    int errors;

    biu_prefetch_queue #(
        .QUEUE_BYTES    (6),
        .ADDR_SIZE      (20),
        .FETCH_THRESHOLD(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .flush_addr (flush_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .q_avail    (q_avail),
        .q_bytes    (q_bytes),
        .eu_imm_sel (eu_imm_sel),
        .eu_word    (eu_word),
        .eu_consume (eu_consume),
        .consume_err(consume_err)
`ifdef PFQ_STATS_EN
        ,
        .fetch_count(fetch_count),
        .flush_count(flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for mem_req; a timeout is reported through check.
    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic ack_word(input logic [15:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        flush      = 1'b1;
        flush_addr = 20'h00100;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        eu_imm_sel = 1'b1;
        eu_consume = 3'd0;

        repeat (3) step();
        check("rst q_avail", 32'(q_avail), 32'd0);
        check("rst q_bytes", q_bytes, 32'h0);
        check("rst eu_word", eu_word, 32'h0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst consume_err", 32'(consume_err), 32'd0);

        // Release reset with flush held so the first fetch starts at 0x00100.
        reset = 1'b0;
        step();
        flush = 1'b0;

        wait_req("req0 issued");
        check("req0 addr", 32'(mem_addr), 32'h00100);
        ack_word(16'h0E09);
        check("req0 dropped", 32'(mem_req), 32'd0);
        check("fill2 q_avail", 32'(q_avail), 32'd2);
        check("fill2 q_bytes", q_bytes, 32'h00000E09);

        wait_req("req1 issued");
        check("req1 addr", 32'(mem_addr), 32'h00102);
        ack_word(16'h3412);
        check("fill4 q_avail", 32'(q_avail), 32'd4);
        check("fill4 q_bytes", q_bytes, 32'h34120E09);
        eu_imm_sel = 1'b1;
        #1;
        check("eu_word imm1", eu_word, 32'h090E3412);
        eu_imm_sel = 1'b0;
        #1;
        check("eu_word imm0", eu_word, 32'h0000090E);
        eu_imm_sel = 1'b1;

        wait_req("req2 issued");
        check("req2 addr", 32'(mem_addr), 32'h00104);
        ack_word(16'h5678);
        check("full q_avail", 32'(q_avail), 32'd6);
        repeat (6) step();
        check("full no req", 32'(mem_req), 32'd0);
        check("full q_avail hold", 32'(q_avail), 32'd6);
        check("full q_bytes", q_bytes, 32'h34120E09);

        // Pop 2 from full: head moves to byte 0x12.
        eu_consume = 3'd2;
        step();
        eu_consume = 3'd0;
        check("pop2 q_avail", 32'(q_avail), 32'd4);
        check("pop2 q_bytes", q_bytes, 32'h56783412);

        // Reservation fills the queue; ack and pop in the same cycle.
        wait_req("req3 issued");
        check("req3 addr", 32'(mem_addr), 32'h00106);
        eu_consume = 3'd2;
        ack_word(16'hBBAA);
        eu_consume = 3'd0;
        check("ack+pop q_avail", 32'(q_avail), 32'd4);
        check("ack+pop q_bytes", q_bytes, 32'hBBAA5678);

        // Pop 2 (next fetch issues on the same edge), then over-consume.
        eu_consume = 3'd2;
        step();
        check("pop to 2 q_avail", 32'(q_avail), 32'd2);
        check("req4 addr", 32'(mem_addr), 32'h00108);
        eu_consume = 3'd4;
        step();
        eu_consume = 3'd0;
        check("over consume err", 32'(consume_err), 32'd1);
        check("over consume q_avail", 32'(q_avail), 32'd2);
        check("over consume q_bytes", q_bytes, 32'h0000BBAA);
        step();
        check("err one pulse", 32'(consume_err), 32'd0);

        // Flush while the request is outstanding: held, then discarded.
        flush      = 1'b1;
        flush_addr = 20'h00201;
        step();
        flush = 1'b0;
        check("discard q_avail", 32'(q_avail), 32'd0);
        check("discard q_bytes", q_bytes, 32'h0);
        check("discard req held", 32'(mem_req), 32'd1);
        repeat (2) step();
        check("discard addr held", 32'(mem_addr), 32'h00108);
        check("discard req still", 32'(mem_req), 32'd1);
        ack_word(16'hDEAD);
        check("discard dropped q_avail", 32'(q_avail), 32'd0);
        check("discard req low", 32'(mem_req), 32'd0);

        // Odd flush address: word at 0x200, only the high byte queued.
        wait_req("req odd issued");
        check("odd addr", 32'(mem_addr), 32'h00200);
        ack_word(16'hAB55);
        check("odd q_avail", 32'(q_avail), 32'd1);
        check("odd q_bytes", q_bytes, 32'h000000AB);
        check("odd eu_word", eu_word, 32'hAB000000);

        // Flush in IDLE with an oversized pop: pop ignored, no error.
        flush      = 1'b1;
        flush_addr = 20'hFFFFE;
        eu_consume = 3'd7;
        step();
        flush      = 1'b0;
        eu_consume = 3'd0;
        check("flush pop ignored err", 32'(consume_err), 32'd0);
        check("flush q_avail", 32'(q_avail), 32'd0);
        check("flush no req", 32'(mem_req), 32'd0);

        wait_req("req wrap0 issued");
        check("wrap0 addr", 32'(mem_addr), 32'hFFFFE);
        ack_word(16'h2211);
        check("wrap0 q_bytes", q_bytes, 32'h00002211);
        wait_req("req wrap1 issued");
        check("wrap1 addr", 32'(mem_addr), 32'h00000);
        ack_word(16'h4433);
        check("wrap1 q_avail", 32'(q_avail), 32'd4);
        check("wrap1 q_bytes", q_bytes, 32'h44332211);

`ifdef PFQ_STATS_EN
        check("fetch_count", 32'(fetch_count), 32'd7);
        check("flush_count", 32'(flush_count), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
